linear_sched: RTL and testbench
===============================

# linear_sched

Sequencing controller for the classifier linear layer (N_IN=50 inputs → N_OUT=20 outputs, 1.7.24 fixed point). It buffers one input vector and walks the weight SRAM output-major, issuing one read per cycle. It accumulates each output with a single signed MAC and streams the 20 results out over a valid/ready handshake, stalling SRAM traffic under output backpressure. It sits between the feature-extraction stage and the softmax/argmax stage and owns the linear-weight SRAM read port.

## Interface
- N_IN, 50, input vector length
- N_OUT, 20, output vector length
- DW, 32, data width (signed 1.7.24)
- ADDR_W, 10, SRAM address width
- FRAC, 24, fractional bits
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the last result is accepted
- in_valid / in_ready  in / out  1  input-word handshake
- in_data  in  DW  input word, signed 1.7.24
- sram_en  out  1  read strobe
- sram_addr  out  ADDR_W  weight address = i*N_OUT + j
- sram_rdata  in  DW  weight, valid exactly 1 cycle after the sram_en cycle
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  DW  result, signed 1.7.24
- out_addr  out  5  output index j

## Operation
- States: IDLE, LOAD, ISSUE, FINISH, DRAIN.
- IDLE: in_ready=0. start=1 → LOAD; counters i, j cleared.
- LOAD: in_ready=1. Each in_valid&&in_ready writes in_data to xbuf[i], i++. After beat N_IN-1 → ISSUE with i=0, j=0.
- ISSUE: per cycle, sram_en=1, sram_addr=i*N_OUT+j, and xbuf[i] is registered alongside it into x_d.
  - Gate applies only at i==0: issue only if slot_ok = !out_valid || out_ready; otherwise sram_en=0 and i holds.
  - With i>0 there is no gating.
  - After i=N_IN-1 → FINISH.
- MAC: in the cycle after each issue, prod = x_d * sram_rdata (signed 32×32 → 64).
  - i==0 product loads acc; later products add to it.
  - acc is 64-bit signed and wraps modulo 2^64; no saturation.
- FINISH: the last product lands. out_data ← (acc+prod)[55:24] (truncation), out_addr ← j, out_valid ← 1, j++, i←0.
  - If j was N_OUT-1 → DRAIN, else → ISSUE.
- DRAIN: wait for out_valid&&out_ready; then out_valid←0, done pulses, → IDLE.
- out_valid, once set, holds with out_data/out_addr stable until accepted. An accept clears out_valid unless FINISH sets it in the same cycle (cannot happen under the gate rule).
- start while busy: ignored. in_valid outside LOAD: ignored (in_ready=0).

## Timing
- Reset values: busy=0, done=0, in_ready=0, sram_en=0, sram_addr=0, out_valid=0, out_data=0, out_addr=0; state IDLE; acc, i, j = 0. xbuf is not reset.
- Reset mid-run (any state): immediate return to all reset values, any in-flight result is discarded, and the next start begins a fresh run.
- LOAD takes at least N_IN cycles; in_valid gaps stall it.
- Each output takes N_IN+1 = 51 cycles (N_IN issue + 1 FINISH) when out_ready=1.
  - First out_valid is registered 51 cycles after ISSUE entry.
  - Results follow every 51 cycles; 1020 cycles from ISSUE entry to the last result.
- Exactly N_IN*N_OUT = 1000 sram_en cycles per run. Address order: 0,20,…,980,1,21,…,999.
- done is asserted in the cycle after the final accept edge; busy falls together with done.

## Structure
- Package linear_pkg holds:
  - N_IN, N_OUT, DW, ADDR_W, FRAC
  - state enum {IDLE, LOAD, ISSUE, FINISH, DRAIN}
  - the Q-format slice helper (bits [FRAC+31:FRAC])
- Sub-module linear_mac contains the registered signed 32×32 multiply, the 64-bit accumulator with load/add control, and the result slice.
- xbuf is a plain N_IN×DW register array inside linear_sched.

## Test plan
- Reset: hold rst_n=0 with random inputs → every output at its reset value. Release: stays IDLE with busy=0 until start.
- All ones: xbuf all 0x01000000 and SRAM all 0x01000000, out_ready=1.
  - out_data=0x32000000 (50.0) for out_addr 0..19 in order, one result every 51 cycles.
  - Single done pulse.
- Signed and address check: x[0]=0xFE800000 (-1.5), SRAM[3]=0x02000000 (2.0), all other weights 0.
  - out_addr 3 gives 0xFD000000 (-3.0); all other outputs 0.
  - Logged sram_addr sequence matches the required order, 1000 strobes.
- Backpressure: out_ready=0 for 200 cycles after the first result.
  - sram_en stays 0 with i=0, and out_data/out_addr stay stable.
  - On release, all results match the all-ones case.
- Mid-run reset: assert rst_n=0 during ISSUE at j=5 → all reset values immediately.
  - A following start plus full load gives the correct 20 results.
- Protocol abuse: start pulsed during ISSUE, and in_valid=1 in IDLE/ISSUE.
  - No restart occurs, in_ready stays 0, and results are unaffected.

Source files
------------

// File: rtl/linear_pkg.sv
// Shared constants, FSM state type and Q-format helper for the linear-layer sequencer.
package linear_pkg;

    localparam int unsigned N_IN   = 50;
    localparam int unsigned N_OUT  = 20;
    localparam int unsigned DW     = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned FRAC   = 24;
    localparam int unsigned ACC_W  = 2 * DW;
    localparam int unsigned IW     = 6;  // holds 0..N_IN-1
    localparam int unsigned JW     = 5;  // holds 0..N_OUT-1

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StFinish,
        StDrain
    } state_e;

    // Pick the 1.7.24 result out of the 2.14.48 accumulator (plain truncation).
    function automatic logic [DW-1:0] q_slice(input logic [ACC_W-1:0] v);
        return v[FRAC+DW-1:FRAC];
    endfunction

endpackage

// File: rtl/linear_mac.sv
// Signed 32x32 multiply feeding a 64-bit wrapping accumulator with load/add control.
module linear_mac
    import linear_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] w_i,
    output logic [DW-1:0] result_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] x_ext, w_ext, prod, sum;

    // Product and running sum; low 64 bits of the sign-extended product is the signed product.
    always_comb begin
        x_ext    = {{DW{x_i[DW-1]}}, x_i};
        w_ext    = {{DW{w_i[DW-1]}}, w_i};
        prod     = x_ext * w_ext;
        sum      = load_i ? prod : acc_q + prod;
        acc_d    = en_i ? sum : acc_q;
        result_o = q_slice(sum);
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/linear_sched.sv
// Linear-layer sequencer: buffers one input vector, walks the weight SRAM output-major,
// accumulates each output with one MAC and streams results over valid/ready.
module linear_sched
    import linear_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DW-1:0]     sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [4:0]        out_addr
);

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   x_q, x_d;
    logic            mac_en_q, mac_en_d;
    logic            mac_load_q, mac_load_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [4:0]      out_addr_q, out_addr_d;
    logic            done_q, done_d;

    logic [DW-1:0]     xbuf [N_IN];
    logic [DW-1:0]     result;
    logic [ADDR_W-1:0] addr_calc;
    logic              load_fire, slot_ok, issue, accept;

    // A new output may only start once the previous result slot is free or being freed.
    assign load_fire = (state_q == StLoad) && in_valid;
    assign slot_ok   = !out_valid_q || out_ready;
    assign issue     = (state_q == StIssue) && ((i_q != '0) || slot_ok);
    assign accept    = out_valid_q && out_ready;
    assign addr_calc = ADDR_W'(i_q) * ADDR_W'(N_OUT) + ADDR_W'(j_q);

    // Input vector capture; never read before being written in a run, so no reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            xbuf[i_q] <= in_data;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        x_d         = x_q;
        mac_en_d    = issue;
        mac_load_d  = issue && (i_q == '0);
        out_valid_d = accept ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    if (i_q == IW'(N_IN - 1)) begin
                        i_d     = '0;
                        state_d = StIssue;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    x_d = xbuf[i_q];
                    if (i_q == IW'(N_IN - 1)) begin
                        state_d = StFinish;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                // Last product lands this cycle; the MAC result already includes it.
                out_valid_d = 1'b1;
                out_data_d  = result;
                out_addr_d  = j_q;
                i_d         = '0;
                if (j_q == JW'(N_OUT - 1)) begin
                    j_d     = '0;
                    state_d = StDrain;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = StIssue;
                end
            end
            StDrain: begin
                if (accept) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            x_q         <= '0;
            mac_en_q    <= 1'b0;
            mac_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            x_q         <= x_d;
            mac_en_q    <= mac_en_d;
            mac_load_q  <= mac_load_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end

    linear_mac u_mac (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (mac_en_q),
        .load_i   (mac_load_q),
        .x_i      (x_q),
        .w_i      (sram_rdata),
        .result_o (result)
    );

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign in_ready  = (state_q == StLoad);
    assign sram_en   = issue;
    assign sram_addr = issue ? addr_calc : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_linear_sched.sv
// Scoreboard bench for linear_sched: directed vectors, SRAM model, address-order logger.
module tb_linear_sched;
    import linear_pkg::*;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DW-1:0]     sram_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [4:0]        out_addr;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] xv [N_IN];
    exp_t          sb_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt, strobe_k, addr_err, t_issue, last_rise;
    bit chk_timing = 1'b0;

    linear_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight SRAM: data one cycle after the strobe.
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_sram_en"}, sram_en, 0);
        check({tag, "_sram_addr"}, sram_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_addr"}, out_addr, 0);
    endtask

    // Pops and compares on every accepted result; also watches done and result spacing.
    task automatic monitor();
        logic prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check("done_busy_low", busy, 0);
                end
                if (chk_timing && out_valid && !prev_valid) begin
                    if (last_rise < 0) check("first_latency", cyc - t_issue, 51);
                    else check("result_period", cyc - last_rise, 51);
                    last_rise = cyc;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got addr %0d data %0h expected none",
                                 out_addr, out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_addr", out_addr, e.addr);
                        check("out_data", out_data, e.data);
                    end
                end
                prev_valid = out_valid;
            end
        end
    endtask

    // Logs every SRAM strobe against the output-major address order.
    task automatic logger();
        int exp_a;
        forever begin
            @(negedge clk);
            if (rst_n && sram_en) begin
                exp_a = (strobe_k % N_IN) * N_OUT + strobe_k / N_IN;
                if (int'(sram_addr) != exp_a) addr_err++;
                if (strobe_k == 0) t_issue = cyc;
                strobe_k++;
            end
        end
    endtask

    task automatic prep_run();
        done_cnt  = 0;
        strobe_k  = 0;
        addr_err  = 0;
        last_rise = -1;
    endtask

    task automatic fill(input logic [DW-1:0] xval, input logic [DW-1:0] wval);
        for (int k = 0; k < N_IN; k++) xv[k] = xval;
        for (int a = 0; a < 1024; a++) mem[a] = wval;
    endtask

    task automatic push_all(input logic [DW-1:0] d);
        for (int j = 0; j < N_OUT; j++) sb_q.push_back({5'(j), d});
    endtask

    task automatic start_and_load(input bit gaps);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("in_ready_load", in_ready, 1);
        for (int k = 0; k < N_IN; k++) begin
            if (gaps && (k % 7 == 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = xv[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic end_run(input string tag);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_sb_left"}, sb_q.size(), 0);
        check({tag, "_strobes"}, strobe_k, 1000);
        check({tag, "_addr_order_err"}, addr_err, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int stall_err;
        prep_run();
        fork
            monitor();
            logger();
        join_none

        // Reset held with random inputs.
        for (int c = 0; c < 6; c++) begin
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom();
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_sram_en", sram_en, 0);

        // All ones with input gaps: 50.0 per output, one result every 51 cycles.
        fill(32'h0100_0000, 32'h0100_0000);
        prep_run();
        chk_timing = 1'b1;
        start_and_load(1'b1);
        push_all(32'h3200_0000);
        end_run("ones");
        chk_timing = 1'b0;

        // Signed product, address mapping and truncation of a negative tiny product.
        fill(32'h0012_3456, 32'h0000_0000);
        xv[0] = 32'hFE80_0000;
        xv[1] = 32'hFFFF_FFFF;
        mem[3]  = 32'h0200_0000;
        mem[25] = 32'h0080_0000;
        prep_run();
        start_and_load(1'b0);
        for (int j = 0; j < N_OUT; j++) begin
            if (j == 3) sb_q.push_back({5'(j), 32'hFD00_0000});
            else if (j == 5) sb_q.push_back({5'(j), 32'hFFFF_FFFF});
            else sb_q.push_back({5'(j), 32'h0000_0000});
        end
        end_run("signed");

        // Backpressure after the first result.
        fill(32'h0100_0000, 32'h0100_0000);
        prep_run();
        out_ready = 1'b0;
        start_and_load(1'b0);
        push_all(32'h3200_0000);
        for (int c = 0; c < 2000 && !out_valid; c++) @(posedge clk);
        check("bp_first_valid", out_valid, 1);
        stall_err = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sram_en !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h3200_0000 ||
                out_addr !== 5'd0) stall_err++;
        end
        check("bp_stall_hold", stall_err, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        end_run("bp");

        // Reset in the middle of output 5, then a fresh run with x = 2.0.
        prep_run();
        start_and_load(1'b0);
        push_all(32'h3200_0000);
        for (int c = 0; c < 2000 && sb_q.size() > 15; c++) @(posedge clk);
        check("mid_five_accepted", sb_q.size(), 15);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", busy, 0);
        fill(32'h0200_0000, 32'h0100_0000);
        prep_run();
        start_and_load(1'b1);
        push_all(32'h6400_0000);
        end_run("after_rst");

        // Protocol abuse: in_valid in IDLE, start and in_valid during ISSUE.
        fill(32'h0100_0000, 32'h0100_0000);
        prep_run();
        in_valid = 1'b1;
        in_data  = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abuse_idle_in_ready", in_ready, 0);
            check("abuse_idle_busy", busy, 0);
        end
        in_valid = 1'b0;
        start_and_load(1'b0);
        push_all(32'h3200_0000);
        repeat (100) @(posedge clk);
        #1 start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abuse_issue_in_ready", in_ready, 0);
            check("abuse_issue_busy", busy, 1);
        end
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b0;
        end_run("abuse");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
